udp_len_csum_insert: RTL
========================

// Module: udp_len_csum_insert
// PURPOSE
//  Store-and-forward stage directly downstream of udp_tx: accepts a full UDP datagram
//  whose length (bytes 4-5) and checksum (bytes 6-7) hold placeholders.
//  Counts bytes and computes the RFC 768 checksum over the IPv4 pseudo-header, UDP header and payload.
//  Replays the datagram with the real length/checksum patched in and presents both values in parallel for the IP/MAC stages.
// PARAMETERS
//  AXI_DATA_WIDTH  8     stream width; only 8 is supported
//  MAX_PKT_BYTES   2048  packet buffer depth in bytes, power of 2, >= 16
//  ADDR_WIDTH      $clog2(MAX_PKT_BYTES)  buffer address width (derived, not overridden)
// PORTS
//  i_clk             in   1   clock
//  i_reset_n         in   1   synchronous, active-low reset
//  s_ip_hdr_tvalid   in   1   pseudo-header addresses valid
//  s_ip_hdr_trdy     out  1   pseudo-header accepted (high only in IDLE)
//  s_ip_src_addr     in   32  IPv4 source address
//  s_ip_dst_addr     in   32  IPv4 destination address
//  s_axis_tdata      in   8   UDP datagram byte from udp_tx
//  s_axis_tvalid     in   1   input byte valid
//  s_axis_tlast      in   1   last datagram byte
//  s_axis_trdy       out  1   input byte ready
//  m_axis_tdata      out  8   patched datagram byte
//  m_axis_tvalid     out  1   output byte valid
//  m_axis_tlast      out  1   last output byte
//  m_axis_trdy       in   1   downstream ready
//  m_udp_length      out  16  datagram length in bytes, header included
//  m_udp_checksum    out  16  final checksum
//  m_udp_meta_valid  out  1   length/checksum valid
//  o_pkt_drop        out  1   1-cycle pulse when a datagram is discarded
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except s_ip_hdr_trdy, which is 1 one cycle after reset release.
//  Reset mid-packet: any partial or buffered datagram is discarded without a drop pulse.
//  IDLE:
//   - s_ip_hdr_trdy=1.
//   - On s_ip_hdr_tvalid, latch both addresses, clear byte count and accumulator, go to STORE.
//  STORE:
//   - s_axis_trdy=1.
//   - Each accepted byte is written to buffer[cnt], then cnt++.
//   - Even cnt: byte adds into the accumulator as a word high byte. Odd cnt: byte adds as the word low byte.
//   - Bytes at cnt 4..7 are summed as zero.
//   - Accumulator is 32 bits with no overflow possible at MAX_PKT_BYTES.
//  On tlast:
//   - len = cnt+1. If len < 8 or len > MAX_PKT_BYTES: pulse o_pkt_drop, go to IDLE.
//   - Otherwise go to FOLD.
//   - Odd len: the final byte is padded with 0x00 as the low byte.
//  Overflow: cnt reaching MAX_PKT_BYTES without tlast sets drop mode.
//   - In drop mode the remaining bytes are accepted and discarded through tlast.
//   - Then o_pkt_drop pulses and the block returns to IDLE.
//  FOLD (3 cycles):
//   - Add src[31:16], src[15:0], dst[31:16], dst[15:0], 0x0011, len, len.
//   - Fold carries twice, then complement.
//   - A result of 0x0000 is sent as 0xFFFF.
//  SEND:
//   - m_udp_meta_valid=1, with m_udp_length/m_udp_checksum stable until the tlast handshake.
//   - Buffer is read sequentially, 1-cycle synchronous RAM plus output register. Ready-independent latency: first m_axis_tvalid 2 cycles after entering SEND.
//   - Byte index 4/5/6/7 is replaced by len[15:8]/len[7:0]/csum[15:8]/csum[7:0].
//   - m_axis_tlast is asserted on index len-1.
//   - m_axis_tdata/tvalid/tlast hold while tvalid & !trdy; no bubbles while trdy stays high.
//   - After the tlast handshake: meta_valid=0, go to IDLE.
//  s_axis_trdy=0 outside STORE; input bytes outside STORE are not consumed.
//  Back-to-back datagrams: the next pseudo-header is accepted the cycle after IDLE is re-entered.
//  Throughput: 1 byte/cycle in and out, no overlap.
// TESTING
//  T1 src 10.0.0.1, dst 10.0.0.2, ports 0x1234->0x5678, payload 41 42 43 44 ->
//     len=0x000C, csum=0xFEA0; out 12 34 56 78 00 0C FE A0 41 42 43 44, tlast on byte 12
//  T2 same with payload 41 42 43 (odd) -> len=0x000B, csum=0xFEE6; tlast on byte 11
//  T3 T1 with m_axis_trdy toggled 1-0-1 every cycle -> identical byte sequence, data held while trdy=0
//  T4 5-byte datagram with tlast -> o_pkt_drop pulses once, no m_axis_tvalid, IDLE next cycle
//  T5 MAX_PKT_BYTES+10 bytes -> all accepted, one o_pkt_drop on tlast, no output; following T1 packet still correct
//  T6 reset asserted at byte 6 of STORE and again mid-SEND -> all outputs 0, next T1 packet correct

Source files
------------

// File: rtl/udp_len_csum_insert.sv
// Store-and-forward UDP stage: buffers a datagram, counts its length, computes the
// RFC 768 checksum, then replays it with length/checksum patched into bytes 4-7.
//
// state   | meaning
// S_IDLE  | waiting for pseudo-header addresses
// S_STORE | buffering datagram bytes, accumulating 16-bit words
// S_DROP  | oversized datagram, swallowing bytes through tlast
// S_FOLD  | adding pseudo-header, folding carries, complementing (3 cycles)
// S_SEND  | replaying buffer with patched length/checksum
module udp_len_csum_insert #(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int MAX_PKT_BYTES  = 2048
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      s_ip_hdr_tvalid,
  output logic                      s_ip_hdr_trdy,
  input  logic [31:0]               s_ip_src_addr,
  input  logic [31:0]               s_ip_dst_addr,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_trdy,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_trdy,
  output logic [15:0]               m_udp_length,
  output logic [15:0]               m_udp_checksum,
  output logic                      m_udp_meta_valid,
  output logic                      o_pkt_drop
);

  localparam int ADDR_WIDTH = $clog2(MAX_PKT_BYTES);
  localparam int CW         = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_STORE, S_DROP, S_FOLD, S_SEND} state_t;

  state_t                    r_state;
  logic [1:0]                r_fold_step;
  logic [31:0]               r_src;
  logic [31:0]               r_dst;
  logic [CW-1:0]             r_cnt;
  logic [31:0]               r_acc;
  logic [15:0]               r_len;
  logic [15:0]               r_csum;
  logic                      r_hdr_trdy;
  logic                      r_in_trdy;
  logic                      r_meta;
  logic                      r_drop;
  logic [CW-1:0]             r_rd_idx;
  logic                      r_q_vld;
  logic [CW-1:0]             r_q_idx;
  logic                      r_out_vld;
  logic [AXI_DATA_WIDTH-1:0] r_out_data;
  logic                      r_out_last;
  logic [AXI_DATA_WIDTH-1:0] r_ram_q;
  logic [AXI_DATA_WIDTH-1:0] r_mem [MAX_PKT_BYTES];

  logic                      w_in_fire;
  logic                      w_wr_en;
  logic [15:0]               w_len_in;
  logic [15:0]               w_in_word;
  logic                      w_adv2;
  logic                      w_rd_en;
  logic                      w_out_fire;
  logic [15:0]               w_fold;
  logic [15:0]               w_csum;
  logic [AXI_DATA_WIDTH-1:0] w_patch;
  logic                      w_q_last;

  assign w_in_fire  = s_axis_tvalid & r_in_trdy;
  assign w_wr_en    = (r_state == S_STORE) & w_in_fire;
  assign w_len_in   = 16'(r_cnt) + 16'd1;
  assign w_adv2     = ~r_out_vld | m_axis_trdy;
  assign w_out_fire = r_out_vld & m_axis_trdy;
  assign w_rd_en    = (r_state == S_SEND) & (16'(r_rd_idx) < r_len) & (~r_q_vld | w_adv2);
  assign w_q_last   = (16'(r_q_idx) == (r_len - 16'd1));

  // Second fold cannot carry: a first-fold result above 0xFFFF has low half <= 0xFFFE.
  assign w_fold = r_acc[15:0] + r_acc[31:16];
  assign w_csum = (w_fold == 16'hFFFF) ? 16'hFFFF : ~w_fold;

  always_comb begin
    w_in_word = 16'h0000;
    if (!((r_cnt >= CW'(4)) && (r_cnt <= CW'(7))))
      w_in_word = r_cnt[0] ? {8'h00, s_axis_tdata} : {s_axis_tdata, 8'h00};
  end

  always_comb begin
    w_patch = r_ram_q;
    case (r_q_idx)
      CW'(4):  w_patch = r_len[15:8];
      CW'(5):  w_patch = r_len[7:0];
      CW'(6):  w_patch = r_csum[15:8];
      CW'(7):  w_patch = r_csum[7:0];
      default: w_patch = r_ram_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_cnt[ADDR_WIDTH-1:0]] <= s_axis_tdata;
    if (w_rd_en) r_ram_q <= r_mem[r_rd_idx[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_fold_step <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_len       <= '0;
      r_csum      <= '0;
      r_hdr_trdy  <= 1'b0;
      r_in_trdy   <= 1'b0;
      r_meta      <= 1'b0;
      r_drop      <= 1'b0;
      r_rd_idx    <= '0;
      r_q_vld     <= 1'b0;
      r_q_idx     <= '0;
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_hdr_trdy <= 1'b1;
          if (s_ip_hdr_tvalid && r_hdr_trdy) begin
            r_src      <= s_ip_src_addr;
            r_dst      <= s_ip_dst_addr;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_hdr_trdy <= 1'b0;
            r_in_trdy  <= 1'b1;
            r_state    <= S_STORE;
          end
        end
        S_STORE: begin
          if (w_in_fire) begin
            r_cnt <= r_cnt + CW'(1);
            r_acc <= r_acc + {16'h0000, w_in_word};
            if (s_axis_tlast) begin
              r_in_trdy <= 1'b0;
              if (w_len_in < 16'd8) begin
                r_drop     <= 1'b1;
                r_hdr_trdy <= 1'b1;
                r_state    <= S_IDLE;
              end else begin
                r_len       <= w_len_in;
                r_fold_step <= '0;
                r_state     <= S_FOLD;
              end
            end else if (r_cnt == CW'(MAX_PKT_BYTES - 1)) begin
              r_state <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (w_in_fire && s_axis_tlast) begin
            r_in_trdy  <= 1'b0;
            r_drop     <= 1'b1;
            r_hdr_trdy <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        S_FOLD: begin
          r_fold_step <= r_fold_step + 2'd1;
          case (r_fold_step)
            2'd0: r_acc <= r_acc + {16'h0000, r_src[31:16]} + {16'h0000, r_src[15:0]}
                         + {16'h0000, r_dst[31:16]} + {16'h0000, r_dst[15:0]}
                         + 32'h0000_0011 + {15'h0000, r_len, 1'b0};
            2'd1: r_acc <= {16'h0000, r_acc[15:0]} + {16'h0000, r_acc[31:16]};
            default: begin
              r_csum    <= w_csum;
              r_meta    <= 1'b1;
              r_rd_idx  <= '0;
              r_q_vld   <= 1'b0;
              r_out_vld <= 1'b0;
              r_state   <= S_SEND;
            end
          endcase
        end
        S_SEND: begin
          if (w_rd_en) begin
            r_rd_idx <= r_rd_idx + CW'(1);
            r_q_idx  <= r_rd_idx;
            r_q_vld  <= 1'b1;
          end else if (w_adv2) begin
            r_q_vld <= 1'b0;
          end
          if (w_adv2) begin
            r_out_vld <= r_q_vld;
            if (r_q_vld) begin
              r_out_data <= w_patch;
              r_out_last <= w_q_last;
            end
          end
          if (w_out_fire && r_out_last) begin
            r_meta     <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_q_vld    <= 1'b0;
            r_hdr_trdy <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ip_hdr_trdy    = r_hdr_trdy;
  assign s_axis_trdy      = r_in_trdy;
  assign m_axis_tdata     = r_out_data;
  assign m_axis_tvalid    = r_out_vld;
  assign m_axis_tlast     = r_out_last;
  assign m_udp_length     = r_len;
  assign m_udp_checksum   = r_csum;
  assign m_udp_meta_valid = r_meta;
  assign o_pkt_drop       = r_drop;

endmodule
